// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU controller.
// Holds the state encoding, opcode/funct values, ALU codes and the strobe bundle.
package cpu_ctrl_pkg;

  localparam int unsigned ALU_CODE_W = 4;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, WB, ADDR, MEM, BRANCH, JUMP
  } state_t;

  // ALU request class handed to the decoder; FUNCT defers to the instruction's funct field
  typedef enum logic [1:0] {
    ALU_OP_NONE, ALU_OP_ADD, ALU_OP_SUB, ALU_OP_FUNCT
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'b0001;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'b0010;
  localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'b0011;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'b0100;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 4'b0101;

  typedef struct packed {
    logic mem_req;
    logic iord;
    logic ir_write;
    logic pc_write;
    logic branch;
    logic reg_dst;
    logic reg_write;
    logic alu_src;
    logic mem_write;
    logic mem_to_reg;
    logic illegal;
  } strobes_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if #(
  parameter int unsigned OPCODE_W   = 6,
  parameter int unsigned FUNCT_W    = 6,
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned CNT_W      = 32
);
  logic [OPCODE_W-1:0]   opcode;
  logic [FUNCT_W-1:0]    funct;
  logic                  zero;
  logic                  mem_ready;
  logic                  mem_req;
  logic                  iord;
  logic                  ir_write;
  logic                  pc_write;
  logic                  branch;
  logic                  reg_dst;
  logic                  reg_write;
  logic                  alu_src;
  logic                  mem_write;
  logic                  mem_to_reg;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  illegal;
  logic [CNT_W-1:0]      cycle_cnt;
  logic [CNT_W-1:0]      instr_cnt;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, iord, ir_write, pc_write, branch, reg_dst, reg_write,
           alu_src, mem_write, mem_to_reg, alu_ctrl, illegal, cycle_cnt, instr_cnt
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, iord, ir_write, pc_write, branch, reg_dst, reg_write,
           alu_src, mem_write, mem_to_reg, alu_ctrl, illegal, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps the controller's ALU request class plus funct to an ALU operation code.
// Flags funct values that have no R-type meaning.
module alu_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned FUNCT_W = 6
) (
  input  alu_op_t               alu_op,
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ALU_CODE_W-1:0] alu_ctrl,
  output logic                  funct_illegal
);

  always_comb begin
    alu_ctrl      = '0;
    funct_illegal = 1'b0;
    case (alu_op)
      ALU_OP_ADD: alu_ctrl = ALU_ADD;
      ALU_OP_SUB: alu_ctrl = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct)
          FUNCT_W'(FN_ADD): alu_ctrl = ALU_ADD;
          FUNCT_W'(FN_SUB): alu_ctrl = ALU_SUB;
          FUNCT_W'(FN_AND): alu_ctrl = ALU_AND;
          FUNCT_W'(FN_OR):  alu_ctrl = ALU_OR;
          FUNCT_W'(FN_SLT): alu_ctrl = ALU_SLT;
          default:          funct_illegal = 1'b1;
        endcase
      end
      default: alu_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences fetch/decode/execute/mem/writeback strobes.
// Define CTRL_PERF_EN to build the cycle/retired-instruction counters.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W   = 6,
  parameter int unsigned FUNCT_W    = 6,
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  state_t                  state_q, state_d;
  logic                    run_q;
  alu_op_t                 alu_op;
  logic [ALU_CODE_W-1:0]   alu_code;
  logic                    funct_illegal;
  strobes_t                s;

  logic op_rtype, op_j, op_beq, op_addi, op_lw, op_sw;
  assign op_rtype = (bus.opcode == OPCODE_W'(OP_RTYPE));
  assign op_j     = (bus.opcode == OPCODE_W'(OP_J));
  assign op_beq   = (bus.opcode == OPCODE_W'(OP_BEQ));
  assign op_addi  = (bus.opcode == OPCODE_W'(OP_ADDI));
  assign op_lw    = (bus.opcode == OPCODE_W'(OP_LW));
  assign op_sw    = (bus.opcode == OPCODE_W'(OP_SW));

  // run_q keeps everything quiet for the first cycle after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    alu_op = ALU_OP_NONE;
    case (state_q)
      FETCH, DECODE, ADDR, MEM: alu_op = ALU_OP_ADD;
      EXEC, WB:                 alu_op = op_rtype ? ALU_OP_FUNCT : ALU_OP_ADD;
      BRANCH:                   alu_op = ALU_OP_SUB;
      default:                  alu_op = ALU_OP_NONE;
    endcase
  end

  alu_decoder #(.FUNCT_W(FUNCT_W)) u_alu_decoder (
    .alu_op        (alu_op),
    .funct         (bus.funct),
    .alu_ctrl      (alu_code),
    .funct_illegal (funct_illegal)
  );

  always_comb begin
    s       = '0;
    state_d = state_q;
    case (state_q)
      FETCH: begin
        s.mem_req = 1'b1;
        s.alu_src = 1'b1;
        if (bus.mem_ready) begin
          s.ir_write = 1'b1;
          s.pc_write = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        s.alu_src = 1'b1;
        if (op_rtype || op_addi)  state_d = EXEC;
        else if (op_lw || op_sw)  state_d = ADDR;
        else if (op_beq)          state_d = BRANCH;
        else if (op_j)            state_d = JUMP;
        else begin
          s.illegal = 1'b1;
          state_d   = FETCH;
        end
      end
      EXEC: begin
        s.alu_src = !op_rtype;
        if (funct_illegal) begin
          s.illegal = 1'b1;
          state_d   = FETCH;
        end else begin
          state_d = WB;
        end
      end
      WB: begin
        s.reg_write  = 1'b1;
        s.reg_dst    = op_rtype;
        s.mem_to_reg = op_lw;
        s.alu_src    = !op_rtype;
        state_d      = FETCH;
      end
      ADDR: begin
        s.alu_src = 1'b1;
        state_d   = MEM;
      end
      MEM: begin
        s.mem_req   = 1'b1;
        s.iord      = 1'b1;
        s.alu_src   = 1'b1;
        s.mem_write = op_sw;
        if (bus.mem_ready) state_d = op_lw ? WB : FETCH;
      end
      BRANCH: begin
        s.branch = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        s.pc_write = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (!run_q) begin
      s       = '0;
      state_d = FETCH;
    end
  end

  assign bus.mem_req    = s.mem_req;
  assign bus.iord       = s.iord;
  assign bus.ir_write   = s.ir_write;
  assign bus.pc_write   = s.pc_write;
  assign bus.branch     = s.branch;
  assign bus.reg_dst    = s.reg_dst;
  assign bus.reg_write  = s.reg_write;
  assign bus.alu_src    = s.alu_src;
  assign bus.mem_write  = s.mem_write;
  assign bus.mem_to_reg = s.mem_to_reg;
  assign bus.illegal    = s.illegal;
  assign bus.alu_ctrl   = run_q ? ALU_CTRL_W'(alu_code) : '0;

`ifdef CTRL_PERF_EN
  logic             retire;
  logic [CNT_W-1:0] cycle_q, instr_q;

  // an illegal abort also returns to FETCH but does not retire
  assign retire = (state_q != FETCH) && (state_d == FETCH) && !s.illegal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (retire) instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign bus.cycle_cnt = cycle_q;
  assign bus.instr_cnt = instr_q;
`else
  assign bus.cycle_cnt = CNT_W'(0);
  assign bus.instr_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected strobe sequences built from the
// instruction rules, compared every cycle, plus literal reset and counter checks.
module tb_multicycle_ctrl;

  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.OPCODE_W(6), .FUNCT_W(6), .ALU_CTRL_W(4), .CNT_W(CW)) bus ();

  multicycle_ctrl #(.OPCODE_W(6), .FUNCT_W(6), .ALU_CTRL_W(4), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [14:0] REQ  = 15'h4000;
  localparam logic [14:0] IORD = 15'h2000;
  localparam logic [14:0] IRW  = 15'h1000;
  localparam logic [14:0] PCW  = 15'h0800;
  localparam logic [14:0] BR   = 15'h0400;
  localparam logic [14:0] DST  = 15'h0200;
  localparam logic [14:0] RW   = 15'h0100;
  localparam logic [14:0] SRC  = 15'h0080;
  localparam logic [14:0] MW   = 15'h0040;
  localparam logic [14:0] M2R  = 15'h0020;
  localparam logic [14:0] ILL  = 15'h0001;

  localparam logic [3:0] C_ADD = 4'b0001;
  localparam logic [3:0] C_SUB = 4'b0010;
  localparam logic [3:0] C_AND = 4'b0011;
  localparam logic [3:0] C_OR  = 4'b0100;
  localparam logic [3:0] C_SLT = 4'b0101;

  typedef struct {
    logic        mr;
    logic [14:0] e;
    bit          ret;
  } item_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc_m = 0;
  int          ins_m = 0;
  bit          prev_ret = 1'b0;
  logic        chk_valid = 1'b0;
  logic [14:0] exp_vec = '0;
  string       cur_name = "";
  int          cur_idx = 0;

  logic [14:0] dvec;
  assign dvec = {bus.mem_req, bus.iord, bus.ir_write, bus.pc_write, bus.branch,
                 bus.reg_dst, bus.reg_write, bus.alu_src, bus.mem_write,
                 bus.mem_to_reg, bus.alu_ctrl, bus.illegal};

  function automatic logic [14:0] A(input logic [3:0] c);
    return {10'b0, c, 1'b0};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [3:0] cnt_exp(input int v);
    logic [3:0] r;
    r = 4'(v);
`ifndef CTRL_PERF_EN
    r = 4'd0;
`endif
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_valid) begin
      check($sformatf("%s[%0d] strobes", cur_name, cur_idx), 32'(dvec), 32'(exp_vec));
      check($sformatf("%s[%0d] cycle_cnt", cur_name, cur_idx), 32'(bus.cycle_cnt), 32'(cnt_exp(cyc_m)));
      check($sformatf("%s[%0d] instr_cnt", cur_name, cur_idx), 32'(bus.instr_cnt), 32'(cnt_exp(ins_m)));
    end
  end

  // Builds the expected per-cycle strobe sequence of one instruction and plays it.
  // sf/sm: mem_ready-low cycles in fetch/mem; lat: hand-computed cycle count; n_run<0 runs all.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int sf,
                           input int sm, input int lat, input int n_run, input string nm);
    item_t       q[$];
    logic [3:0]  code;
    bit          fn_ok;
    bit          known;
    logic [14:0] m;
    fn_ok = 1'b1;
    case (fn)
      6'h20:   code = C_ADD;
      6'h22:   code = C_SUB;
      6'h24:   code = C_AND;
      6'h25:   code = C_OR;
      6'h2A:   code = C_SLT;
      default: begin code = 4'd0; fn_ok = 1'b0; end
    endcase
    known = (op == 6'h00) || (op == 6'h02) || (op == 6'h04) || (op == 6'h08) ||
            (op == 6'h23) || (op == 6'h2B);
    for (int i = 0; i < sf; i++) q.push_back('{mr: 1'b0, e: REQ | SRC | A(C_ADD), ret: 1'b0});
    q.push_back('{mr: 1'b1, e: REQ | IRW | PCW | SRC | A(C_ADD), ret: 1'b0});
    q.push_back('{mr: rnd(), e: SRC | A(C_ADD) | (known ? 15'h0 : ILL), ret: 1'b0});
    case (op)
      6'h00: begin
        if (fn_ok) begin
          q.push_back('{mr: rnd(), e: A(code), ret: 1'b0});
          q.push_back('{mr: rnd(), e: RW | DST | A(code), ret: 1'b1});
        end else begin
          q.push_back('{mr: rnd(), e: ILL, ret: 1'b0});
        end
      end
      6'h08: begin
        q.push_back('{mr: rnd(), e: SRC | A(C_ADD), ret: 1'b0});
        q.push_back('{mr: rnd(), e: RW | SRC | A(C_ADD), ret: 1'b1});
      end
      6'h23, 6'h2B: begin
        m = REQ | IORD | SRC | A(C_ADD) | ((op == 6'h2B) ? MW : 15'h0);
        q.push_back('{mr: rnd(), e: SRC | A(C_ADD), ret: 1'b0});
        for (int i = 0; i < sm; i++) q.push_back('{mr: 1'b0, e: m, ret: 1'b0});
        q.push_back('{mr: 1'b1, e: m, ret: (op == 6'h2B)});
        if (op == 6'h23) q.push_back('{mr: rnd(), e: RW | M2R | SRC | A(C_ADD), ret: 1'b1});
      end
      6'h04: q.push_back('{mr: rnd(), e: BR | A(C_SUB), ret: 1'b1});
      6'h02: q.push_back('{mr: rnd(), e: PCW, ret: 1'b1});
      default: ;
    endcase
    check({nm, " latency"}, 32'(q.size()), 32'(lat));
    for (int i = 0; i < q.size() && (n_run < 0 || i < n_run); i++) begin
      @(posedge clk);
      #1;
      cyc_m++;
      if (prev_ret) ins_m++;
      prev_ret      = q[i].ret;
      bus.opcode    = op;
      bus.funct     = fn;
      bus.zero      = rnd();
      bus.mem_ready = q[i].mr;
      exp_vec       = q[i].e;
      cur_name      = nm;
      cur_idx       = i;
      chk_valid     = 1'b1;
    end
    @(negedge clk);
    #1 chk_valid = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    chk_valid     = 1'b0;
    bus.mem_ready = 1'b1;
    rst           = 1'b0;
    #1;
    check({nm, " strobes at reset assert"}, 32'(dvec), 32'h0);
    check({nm, " cycle_cnt at reset"}, 32'(bus.cycle_cnt), 32'h0);
    check({nm, " instr_cnt at reset"}, 32'(bus.instr_cnt), 32'h0);
    @(posedge clk);
    #1;
    check({nm, " strobes held in reset"}, 32'(dvec), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check({nm, " strobes before first edge"}, 32'(dvec), 32'h0);
    cyc_m    = 0;
    ins_m    = 0;
    prev_ret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.opcode    = '0;
    bus.funct     = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    do_reset("por");

    run_instr(6'h08, 6'h00, 0, 0, 4, -1, "addi");
    run_instr(6'h00, 6'h2A, 0, 0, 4, -1, "r_slt");
    run_instr(6'h23, 6'h00, 0, 3, 8, -1, "lw_wait3");
    run_instr(6'h3F, 6'h00, 0, 0, 2, -1, "bad_opcode");
    run_instr(6'h2B, 6'h00, 1, 0, 5, -1, "sw_fetchwait");
    run_instr(6'h00, 6'h20, 0, 0, 4, -1, "r_add");
    run_instr(6'h00, 6'h22, 0, 0, 4, -1, "r_sub");
    run_instr(6'h00, 6'h24, 0, 0, 4, -1, "r_and");
    run_instr(6'h00, 6'h25, 0, 0, 4, -1, "r_or");
    run_instr(6'h00, 6'h3F, 0, 0, 3, -1, "r_bad_funct");
    run_instr(6'h04, 6'h00, 0, 0, 3, -1, "beq");
    run_instr(6'h02, 6'h00, 2, 0, 5, -1, "j_fetchwait2");
    run_instr(6'h2B, 6'h00, 0, 2, 6, -1, "sw_wait2");
    run_instr(6'h23, 6'h00, 0, 0, 5, -1, "lw");

    // abort an LW while it waits in MEM
    run_instr(6'h23, 6'h00, 0, 3, 8, 5, "lw_abort");
    do_reset("mid_mem");

    for (int k = 0; k < 20; k++) run_instr(6'h04, 6'h00, 0, 0, 3, -1, "beq_run");
    @(posedge clk);
    #1;
`ifdef CTRL_PERF_EN
    check("beq_run cycle_cnt wrap", 32'(bus.cycle_cnt), 32'd13);
    check("beq_run instr_cnt wrap", 32'(bus.instr_cnt), 32'd4);
`else
    check("beq_run cycle_cnt tied", 32'(bus.cycle_cnt), 32'd0);
    check("beq_run instr_cnt tied", 32'(bus.instr_cnt), 32'd0);
`endif
    check("beq_run back in fetch", 32'(bus.mem_req), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
